bram_fifo: RTL and testbench

//  Synchronous FIFO built on an inferred simple-dual-port block RAM, with registered read port.

---
 rtl/bram_fifo.sv | 179 +++++++++++++++++
 tb/tb_bram_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo.sv
// -----------------------------------------------------------------------------
// bram_fifo
//   Synchronous FIFO on an inferred simple-dual-port block RAM with a
//   registered read port. Elastic buffer between the USB packet engine and
//   the endpoint logic.
//
//   Build option (macro BRAM_FIFO_FWFT_EN):
//     undefined : standard mode, dout valid the cycle after an accepted rd.
//     defined   : first-word-fall-through, head word presented on dout
//                 whenever empty==0; rd acknowledges and pops it.
//
// Parameters
//   DW  data word width in bits
//   AW  address width; storage depth = 2**AW words
//
// Ports
//   clk    in   1     single clock, posedge
//   rst_n  in   1     asynchronous active-low reset
//   wr     in   1     write request, accepted when wr && !full
//   din    in   DW    write data
//   rd     in   1     read request / pop, accepted when rd && !empty
//   dout   out  DW    read data (registered)
//   empty  out  1     no word available to read
//   full   out  1     level == 2**AW
//   level  out  AW+1  words held (0..2**AW)
//   ovf    out  1     1-cycle pulse after a write attempted while full
//   unf    out  1     1-cycle pulse after a read attempted while empty
// -----------------------------------------------------------------------------
module bram_fifo #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          unf
);

  localparam int unsigned DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] r_mem [DEPTH_I];

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW:0]   r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_ovf;
  logic          r_unf;
  logic [DW-1:0] r_dout;

  logic          w_wr_ok;
  logic          w_pop;
  logic [AW:0]   w_level_nxt;

  assign w_wr_ok = wr & ~r_full;
  assign w_pop   = rd & ~r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_ok && !w_pop)
      w_level_nxt = r_level + ONE;
    else if (!w_wr_ok && w_pop)
      w_level_nxt = r_level - ONE;
  end

  // Storage array is never reset; reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[r_wptr[AW-1:0]] <= din;
  end

  // Write side, occupancy and error pulses are common to both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_ok)
        r_wptr <= r_wptr + ONE;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == DEPTH);
      r_ovf   <= wr & r_full;
      r_unf   <= rd & r_empty;
    end
  end

`ifdef BRAM_FIFO_FWFT_EN
  // Prefetch: the RAM registered read port feeds r_dout directly. A word is
  // pulled in EMPTY, qualified one cycle later in FETCH, and while VALID each
  // pop immediately refills r_dout from the RAM so bursts have no bubbles.
  typedef enum logic [1:0] {
    S_EMPTY,
    S_FETCH,
    S_VALID
  } state_t;

  state_t      r_state;
  logic [AW:0] w_ram_cnt;
  logic        w_ram_avail;

  // Words still in the RAM, excluding the one already in r_dout.
  assign w_ram_cnt   = r_wptr - r_rptr;
  assign w_ram_avail = (w_ram_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_rptr  <= '0;
      r_dout  <= '0;
      r_empty <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_ram_avail) begin
            r_dout  <= r_mem[r_rptr[AW-1:0]];
            r_rptr  <= r_rptr + ONE;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_VALID;
          r_empty <= 1'b0;
        end
        S_VALID: begin
          if (rd) begin
            if (w_ram_avail) begin
              r_dout <= r_mem[r_rptr[AW-1:0]];
              r_rptr <= r_rptr + ONE;
            end else begin
              r_state <= S_EMPTY;
              r_empty <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_empty <= 1'b1;
        end
      endcase
    end
  end
`else
  // Standard mode: dout loads only on an accepted read and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_dout  <= '0;
      r_empty <= 1'b1;
    end else begin
      if (w_pop) begin
        r_dout <= r_mem[r_rptr[AW-1:0]];
        r_rptr <= r_rptr + ONE;
      end
      r_empty <= (w_level_nxt == '0);
    end
  end
`endif

  assign dout  = r_dout;
  assign empty = r_empty;
  assign full  = r_full;
  assign level = r_level;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_bram_fifo.sv
module tb_bram_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          wr;
  logic [DW-1:0] din;
  logic          rd;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          ovf;
  logic          unf;

  bram_fifo #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .din   (din),
    .rd    (rd),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .level (level),
    .ovf   (ovf),
    .unf   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int mlevel  = 0;
  logic [DW-1:0] sb_q[$];
  logic pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; expected data enters the scoreboard only
  // when the hand-tracked occupancy says the write is accepted.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic w_acc;
    logic r_acc;
    w_acc = w && (mlevel < DEPTH);
    r_acc = r && (mlevel > 0);
    wr  = w;
    din = d;
    rd  = r;
    if (w_acc) sb_q.push_back(d);
    mlevel = mlevel + int'(w_acc) - int'(r_acc);
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  // Monitor: compares dout with the scoreboard whenever a word is delivered.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
`ifdef BRAM_FIFO_FWFT_EN
      if (rd && !empty) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_dout", {24'd0, dout}, {24'd0, sb_q.pop_front()});
      end
`else
      if (pend) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_dout", {24'd0, dout}, {24'd0, sb_q.pop_front()});
      end
      pend = rd && !empty;
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    din = '0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: reset state, three words in and out
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_dout",  {24'd0, dout},  32'd0);
    chk("rst_ovf",   {31'd0, ovf},   32'd0);
    chk("rst_unf",   {31'd0, unf},   32'd0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("t1_level3", {27'd0, level}, 32'd3);
    chk("t1_empty0", {31'd0, empty}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_level0", {27'd0, level}, 32'd0);
    chk("t1_empty1", {31'd0, empty}, 32'd1);
    chk("t1_dout_hold", {24'd0, dout}, 32'h33);

    // Test 2: fill to full, overflow drops the extra word
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_level16", {27'd0, level}, 32'd16);
    chk("t2_ovf_idle", {31'd0, ovf}, 32'd0);
    step(1'b1, 8'hEE, 1'b0);
    chk("t2_ovf_pulse", {31'd0, ovf}, 32'd1);
    chk("t2_level_hold", {27'd0, level}, 32'd16);
    chk("t2_full_hold", {31'd0, full}, 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("t2_ovf_clear", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t2_drained_level", {27'd0, level}, 32'd0);
    chk("t2_drained_empty", {31'd0, empty}, 32'd1);
    chk("t2_drained_full", {31'd0, full}, 32'd0);

    // Test 3: underflow
    step(1'b0, 8'h00, 1'b1);
    chk("t3_unf_pulse", {31'd0, unf}, 32'd1);
    chk("t3_dout_hold", {24'd0, dout}, 32'h4F);
    chk("t3_level0", {27'd0, level}, 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("t3_unf_clear", {31'd0, unf}, 32'd0);

    // Test 4: steady state at level 5 with simultaneous wr+rd, pointers wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    chk("t4_level5", {27'd0, level}, 32'd5);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'h65 + 8'(i), 1'b1);
      chk("t4_level_steady", {27'd0, level}, 32'd5);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_empty", {31'd0, empty}, 32'd1);

    // Test 5: reset mid-stream at level 8
    for (int i = 0; i < 8; i++) step(1'b1, 8'h80 + 8'(i), 1'b0);
    chk("t5_level8", {27'd0, level}, 32'd8);
    wr  = 1'b1;
    din = 8'h88;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_level", {27'd0, level}, 32'd0);
    chk("t5_rst_empty", {31'd0, empty}, 32'd1);
    chk("t5_rst_full",  {31'd0, full},  32'd0);
    chk("t5_rst_dout",  {24'd0, dout},  32'd0);
    wr = 1'b0;
    sb_q.delete();
    mlevel = 0;
    @(posedge clk);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_after_level", {27'd0, level}, 32'd0);
    chk("t5_after_dout", {24'd0, dout}, 32'h5A);

    // Test 6: output latency and a four-word burst read
    step(1'b1, 8'hA5, 1'b0);
`ifdef BRAM_FIFO_FWFT_EN
    chk("t6_empty_n0", {31'd0, empty}, 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_empty_n1", {31'd0, empty}, 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_empty_n2", {31'd0, empty}, 32'd0);
    chk("t6_dout_n2", {24'd0, dout}, 32'hA5);
    step(1'b0, 8'h00, 1'b1);
`else
    chk("t6_empty_n0", {31'd0, empty}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_dout_rd", {24'd0, dout}, 32'hA5);
`endif
    step(1'b0, 8'h00, 1'b0);
    chk("t6_empty_after", {31'd0, empty}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC1 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("t6_burst_empty", {31'd0, empty}, 32'd1);
    chk("t6_burst_level", {27'd0, level}, 32'd0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    chk("sb_leftover", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
